mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
- Sequences MEM-stage data accesses onto an external 16-bit asynchronous SRAM.
- Each 32-bit load or store is split into two half-word phases, with programmable wait states per phase.
- Drives `ready`. The top level inverts it into the `freeze` input of the MEM/WB stage register and the upstream stage registers.
- Sits between the MEM-stage address/data and the SRAM pins. It replaces the single-cycle data-memory model.

Parameters:
- WAIT_CYCLES, 1, extra cycles held per half-word phase (legal 0..7); each phase lasts WAIT_CYCLES+1 cycles.
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wr_en  in  1  MEM-stage store request
- rd_en  in  1  MEM-stage load request
- address  in  32  byte address (ALU result)
- write_data  in  32  store data
- read_data  out  32  load result, valid when ready=1 in DONE
- ready  out  1  access complete / no access; 0 freezes the pipeline
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable (1 = drive)
- sram_dq_in  in  16  read data from pad
- sram_we_n  out  1  write strobe, active low
- sram_oe_n  out  1  read output enable, active low

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - state=IDLE, wait counter=0, read_data=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
  - sram_addr=0, sram_dq_out=0.
- Reset mid-access abandons the access immediately; no partial write completes after rst deasserts.
- Word index: widx=(address-ADDR_BASE)>>2, truncated to SRAM_AW-1 bits.
  - Low half-word at {widx,0}; high half-word at {widx,1}.
  - Addresses below ADDR_BASE wrap modulo 2^32; no error is flagged.
- Request: req=wr_en|rd_en. If both are asserted, the write wins and the access is treated as a store.
- States:
  - IDLE: if req, latch op, widx, write_data, then go to LO. Otherwise stay in IDLE.
  - LO:
    - sram_addr={widx,0}, held for WAIT_CYCLES+1 cycles.
    - Store: sram_dq_oe=1, sram_dq_out=wdata[15:0], sram_we_n=0 every cycle of the phase.
    - Load: sram_oe_n=0; capture sram_dq_in into read_data[15:0] on the final cycle of the phase.
    - Then go to HI.
  - HI: same as LO with {widx,1} and bits [31:16], then go to DONE.
  - DONE: strobes deasserted, ready=1, next state IDLE unconditionally.
- ready (combinational):
  - 1 in DONE.
  - 1 in IDLE with req=0.
  - 0 in IDLE with req=1, and 0 in LO and HI.
- Freeze therefore takes effect in the same cycle the request first appears.
- Latency: ready is low for 2*(WAIT_CYCLES+1)+1 cycles, then high for 1 cycle (DONE).
- The pipeline advances on the DONE edge. A new request seen in the following IDLE cycle starts immediately.
- read_data holds its value until the next load overwrites it. Stores do not modify read_data.
- Between phases, sram_we_n returns to 1 for zero cycles; the address changes together with the strobe. The SRAM part chosen tolerates this.
- wr_en, rd_en, address and write_data may change during LO/HI; the latched copies are used.

Optional Feature:
- Macro: MEM_SRAM_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0], reset to 0.
  - Increments every cycle ready=0 and saturates at 0xFFFFFFFF.
  - Adds input stall_cnt_clr [1], a synchronous clear with priority over increment.
- When undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3;
  - ADDR_BASE default;
  - SRAM width constants (16-bit data, 18-bit address).
- One sub-module, mem_sram_wait_cnt: loadable down-counter with a terminal-count output, used for phase timing.

Test Plan (WAIT_CYCLES=1):
- Reset held 3 cycles, then released with no request -> ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
- Store 0xDEADBEEF to address 1028:
  - Required: ready=0 for 5 cycles.
  - Addr 2 with dq_out 0xBEEF and we_n=0 for 2 cycles, then addr 3 with 0xDEAD for 2 cycles.
  - ready=1 in the 6th cycle.
- Load from 1028 after the above store -> read_data=0xDEADBEEF in the DONE cycle; sram_we_n stays 1 throughout.
- wr_en=1 and rd_en=1 at address 1032 with data 0x12345678 -> performs a store to half-words 4/5; read_data unchanged.
- Assert rst during the HI phase of a store -> sram_we_n=1 and state IDLE asynchronously; a subsequent load of that word shows the high half unchanged.
- Back-to-back loads at 1024 then 1036 -> second access starts the cycle after DONE; 10 cycles of ready=0 in total. With MEM_SRAM_STALL_CNT_EN, stall_cnt=10.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// mem_sram_ctrl_pkg: state encoding and SRAM geometry shared by the SRAM controller files.
package mem_sram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;
    localparam int ADDR_BASE_DEF = 1024;
    localparam int SRAM_DW = 16;
    localparam int SRAM_AW_DEF = 18;
    localparam int CNT_W = 3;
endpackage

// File: rtl/mem_sram_wait_cnt.sv
// mem_sram_wait_cnt: loadable down-counter; o_tc flags the last cycle of a phase.
module mem_sram_wait_cnt import mem_sram_ctrl_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;

    assign o_tc = r_cnt == '0;
endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: splits 32-bit MEM-stage accesses into two half-word phases on a 16-bit async SRAM.
// Optional MEM_SRAM_STALL_CNT_EN adds a saturating stall-cycle counter with synchronous clear.
module mem_sram_ctrl import mem_sram_ctrl_pkg::*; #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BASE   = ADDR_BASE_DEF,
    parameter int SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
`ifdef MEM_SRAM_STALL_CNT_EN
    ,
    input  logic               stall_cnt_clr,
    output logic [31:0]        stall_cnt
`endif
);
    localparam int WW = SRAM_AW - 1;

    state_t            r_state, w_next;
    logic              r_wr;
    logic [WW-1:0]     r_widx;
    logic [31:0]       r_wdata, r_rdata;
    logic              w_req, w_start, w_tc, w_load, w_phase;

    assign w_req   = wr_en | rd_en;
    assign w_start = r_state == IDLE && w_req;
    assign w_load  = w_start || (r_state == LO && w_tc);
    assign w_phase = r_state == LO || r_state == HI;

    mem_sram_wait_cnt u_wait (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (CNT_W'(WAIT_CYCLES)),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_req ? LO : IDLE;
            LO:      w_next = w_tc ? HI : LO;
            HI:      w_next = w_tc ? DONE : HI;
            default: w_next = IDLE;
        endcase
    end

    // Store wins when both requests are present, hence r_wr takes wr_en directly.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr    <= 1'b0;
            r_widx  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_wr    <= wr_en;
                r_widx  <= WW'((address - 32'(ADDR_BASE)) >> 2);
                r_wdata <= write_data;
            end
            if (!r_wr && w_tc && r_state == LO) r_rdata[15:0] <= sram_dq_in;
            if (!r_wr && w_tc && r_state == HI) r_rdata[31:16] <= sram_dq_in;
        end

    always_comb begin
        ready       = r_state == DONE || (r_state == IDLE && !w_req);
        sram_addr   = w_phase ? {r_widx, r_state == HI} : '0;
        sram_dq_out = (w_phase && r_wr) ? (r_state == HI ? r_wdata[31:16] : r_wdata[15:0]) : '0;
        sram_dq_oe  = w_phase && r_wr;
        sram_we_n   = !(w_phase && r_wr);
        sram_oe_n   = !(w_phase && !r_wr);
    end

    assign read_data = r_rdata;

`ifdef MEM_SRAM_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_stall <= '0;
        else if (stall_cnt_clr) r_stall <= '0;
        else if (!ready && r_stall != '1) r_stall <= r_stall + 1'b1;

    assign stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed checks of mem_sram_ctrl (WAIT_CYCLES=1) against a behavioural SRAM.
module tb_mem_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_dq_oe, sram_we_n, sram_oe_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
`ifdef MEM_SRAM_STALL_CNT_EN
    logic        stall_cnt_clr;
    logic [31:0] stall_cnt;
`endif
    int checks = 0;
    int errors = 0;
    logic [15:0] mem [0:262143];

    always #5 clk = ~clk;

    mem_sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
`ifdef MEM_SRAM_STALL_CNT_EN
        ,
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt)
`endif
    );

    // Behavioural SRAM: latches write data at any clock edge that sees the strobe low.
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    assign sram_dq_in = !sram_oe_n ? mem[sram_addr] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access from IDLE (called just after a falling edge) and checks every cycle through DONE.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [17:0] ha, input logic [31:0] exp_rd);
        wr_en = w; rd_en = r; address = a; write_data = d;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFF0; write_data = 32'h0BAD_0BAD;
            end
            #1;
            check($sformatf("ready c%0d", i), {31'd0, ready}, {31'd0, i == 5});
            if (i >= 1 && i <= 4) begin
                check($sformatf("addr c%0d", i), {14'd0, sram_addr}, {14'd0, (i <= 2) ? ha : ha + 18'd1});
                check($sformatf("we_n c%0d", i), {31'd0, sram_we_n}, {31'd0, !w});
                check($sformatf("oe_n c%0d", i), {31'd0, sram_oe_n}, {31'd0, w});
                check($sformatf("dq_oe c%0d", i), {31'd0, sram_dq_oe}, {31'd0, w});
                if (w) check($sformatf("dq_out c%0d", i), {16'd0, sram_dq_out}, {16'd0, (i <= 2) ? d[15:0] : d[31:16]});
            end else begin
                check($sformatf("we_n idle c%0d", i), {31'd0, sram_we_n}, 32'd1);
                check($sformatf("oe_n idle c%0d", i), {31'd0, sram_oe_n}, 32'd1);
            end
            if (i == 5) check("read_data done", read_data, exp_rd);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'hA000 + 16'(i & 16'hFF);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
`ifdef MEM_SRAM_STALL_CNT_EN
        stall_cnt_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst ready", {31'd0, ready}, 32'd1);
        check("rst we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst read_data", read_data, 32'd0);
        check("rst addr", {14'd0, sram_addr}, 32'd0);
        check("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
        @(negedge clk);

        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'd1032, 32'h12345678, 18'd4, 32'hDEADBEEF);
        check("mem hw4", {16'd0, mem[4]}, 32'h5678);
        check("mem hw5", {16'd0, mem[5]}, 32'h1234);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'h12345678);

        // Store abandoned by reset in the first HI cycle.
        wr_en = 1'b1; address = 32'd1028; write_data = 32'hCAFEF00D;
        @(negedge clk);
        wr_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("hi we_n before rst", {31'd0, sram_we_n}, 32'd0);
        check("hi addr before rst", {14'd0, sram_addr}, 32'd3);
        rst = 1'b1;
        #1;
        check("async rst we_n", {31'd0, sram_we_n}, 32'd1);
        check("async rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("async rst state", {30'd0, dut.r_state}, 32'd0);
        check("async rst read_data", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADF00D);

`ifdef MEM_SRAM_STALL_CNT_EN
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        stall_cnt_clr = 1'b0;
        #1;
        check("stall_cnt cleared", stall_cnt, 32'd0);
        @(negedge clk);
`endif
        access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'hA001A000);
        access(1'b0, 1'b1, 32'd1036, 32'h0, 18'd6, 32'hA007A006);
`ifdef MEM_SRAM_STALL_CNT_EN
        #1;
        check("stall_cnt b2b", stall_cnt, 32'd10);
`endif
        repeat (2) @(negedge clk);
        #1;
        check("read_data hold", read_data, 32'hA007A006);
        check("idle ready", {31'd0, ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
